// File: rtl/mem_to_reg_mux_if.sv
// Write-back selector bus: eight candidate values, a select code and the
// registered result heading to the register-file write-data port.
interface mem_to_reg_mux_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [WIDTH-1:0] entry2;
    logic [WIDTH-1:0] entry3;
    logic [WIDTH-1:0] entry4;
    logic [WIDTH-1:0] entry5;
    logic [WIDTH-1:0] entry6;
    logic [WIDTH-1:0] entry7;
    logic [2:0]       controlSingal;
    logic [WIDTH-1:0] out;

    // Datapath/control side: supplies candidates and the code, consumes the result.
    modport master (
        output entry0, entry1, entry2, entry3,
        output entry4, entry5, entry6, entry7,
        output controlSingal,
        input  out
    );

    // Selector side.
    modport slave (
        input  entry0, entry1, entry2, entry3,
        input  entry4, entry5, entry6, entry7,
        input  controlSingal,
        output out
    );

endinterface

// File: rtl/mem_to_reg_mux.sv
// Write-back source selector: 8-way mux of bit-exact candidates into a single
// output register that reloads every cycle. Reset is synchronous and wins over
// selection.
module mem_to_reg_mux #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_to_reg_mux_if.slave   bus
);

    logic [WIDTH-1:0] sel_value;
    logic [WIDTH-1:0] out_q;

    // Combinational 8-way select; every code is legal.
    always_comb begin
        // Unknown code propagates as unknown rather than being forced to a value.
        sel_value = 'x;
        unique case (bus.controlSingal)
            3'd0: sel_value = bus.entry0;
            3'd1: sel_value = bus.entry1;
            3'd2: sel_value = bus.entry2;
            3'd3: sel_value = bus.entry3;
            3'd4: sel_value = bus.entry4;
            3'd5: sel_value = bus.entry5;
            3'd6: sel_value = bus.entry6;
            3'd7: sel_value = bus.entry7;
        endcase
    end

    // Output register: clear on reset, otherwise load the selection each edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= sel_value;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_mem_to_reg_mux.sv
// Self-checking bench for mem_to_reg_mux. Expected outputs are queued when a
// cycle's stimulus is driven and popped after the edge that should produce them.
module tb_mem_to_reg_mux;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic reset;

    mem_to_reg_mux_if #(.WIDTH(WIDTH)) bus ();

    mem_to_reg_mux #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] ent [8];
    logic [WIDTH-1:0] exp_q [$];
    string            tag_q [$];

    int n_compared;
    int n_mismatch;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        n_compared++;
        if (obs !== expv) begin
            n_mismatch++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, expv);
        end
    endtask

    task automatic load_sweep_values();
        ent[0] = 32'h0000_FFFF;
        ent[1] = 32'h0000_01FF;
        ent[2] = 32'h0000_001F;
        ent[3] = 32'h0000_0001;
        ent[4] = 32'h0000_0000;
        ent[5] = 32'hFFFF_FFFF;
        ent[6] = 32'hF000_FFFF;
        ent[7] = 32'hAAAA_FFFF;
    endtask

    task automatic drive_inputs(input logic rst, input logic [2:0] sel);
        reset             = rst;
        bus.controlSingal = sel;
        bus.entry0        = ent[0];
        bus.entry1        = ent[1];
        bus.entry2        = ent[2];
        bus.entry3        = ent[3];
        bus.entry4        = ent[4];
        bus.entry5        = ent[5];
        bus.entry6        = ent[6];
        bus.entry7        = ent[7];
    endtask

    // One cycle: drive, queue the expected result, step past the edge, compare.
    task automatic run_cycle(input string tag, input logic rst, input logic [2:0] sel);
        logic [WIDTH-1:0] expv;
        string            t;
        drive_inputs(rst, sel);
        exp_q.push_back(rst ? '0 : ent[sel]);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL %s: scoreboard empty at compare", tag);
        end else begin
            expv = exp_q.pop_front();
            t    = tag_q.pop_front();
            check(t, bus.out, expv);
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatch = 0;
        load_sweep_values();
        drive_inputs(1'b1, 3'd5);
        #1;

        // Reset clears even with an all-ones entry selected, and holds.
        run_cycle("reset_first_edge", 1'b1, 3'd5);
        for (int i = 0; i < 3; i++) run_cycle("reset_hold", 1'b1, 3'd5);

        // Full sweep; first edge after reset loads the selection.
        for (int c = 0; c < 8; c++) run_cycle($sformatf("sweep_code%0d", c), 1'b0, 3'(c));
        run_cycle("sweep_wrap_7_to_0", 1'b0, 3'd0);

        // Latency: out keeps the old value until the edge after the code change.
        run_cycle("latency_code3", 1'b0, 3'd3);
        drive_inputs(1'b0, 3'd6);
        #2;
        check("latency_before_edge", bus.out, 32'h0000_0001);
        run_cycle("latency_code6", 1'b0, 3'd6);

        // Isolation: non-selected entries churn, code 2 output stays fixed.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) if (k != 2) ent[k] = $urandom;
            run_cycle("isolation_code2", 1'b0, 3'd2);
            check("isolation_value", bus.out, 32'h0000_001F);
        end

        // Mid-stream reset on code 7: one zero cycle, then resume.
        load_sweep_values();
        run_cycle("midrst_pre", 1'b0, 3'd7);
        run_cycle("midrst_pre", 1'b0, 3'd7);
        run_cycle("midrst_zero", 1'b1, 3'd7);
        run_cycle("midrst_resume", 1'b0, 3'd7);
        check("midrst_resume_val", bus.out, 32'hAAAA_FFFF);

        // Simultaneous code and entry change lands together.
        ent[1] = 32'h1234_5678;
        run_cycle("simul_change", 1'b0, 3'd1);

        // Live tracking of a counting entry.
        for (int i = 0; i < 8; i++) begin
            ent[4] = 32'(i);
            run_cycle($sformatf("track_%0d", i), 1'b0, 3'd4);
        end

        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatch++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/mem_to_reg_mux.md
# mem_to_reg_mux

Write-back source selector for the register file datapath. It selects one of eight 32-bit candidate values and delivers the result through an output register, based on a 3-bit control code from the control unit. It sits between the datapath result sources (ALU, memory data, shifter, immediates, PC, etc.) and the register-file write-data port.

## Interface
- WIDTH, 32, data width of every entry and of out.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- entry0 … entry7  input  WIDTH each  candidate write-back values, index = selection code.
- controlSingal  input  3  selection code (0–7) from the control unit.
- out  output  WIDTH  registered selected value.

## Operation
- Selection is combinational: sel_value = entryN where N = unsigned(controlSingal).
- All 8 codes are valid. There is no default or illegal code.
- out is a register. On each rising clk edge:
  - if reset = 1: out <= 0;
  - else: out <= sel_value.
- No enable input. out reloads every cycle.
- Entries are passed bit-exact. There is no sign or zero extension, no arithmetic, and no width conversion.
- X/Z on controlSingal must not be masked. The register takes whatever the simulator resolves; the bench drives known values only.
- Implement using one case statement (or an equivalent 8-way mux) feeding a single always @(posedge clk) register. No latches and no inferred combinational loops.

## Timing
- Reset value: out = 32'h0000_0000. It applies on the first rising edge with reset = 1 and holds while reset stays high.
- Latency is 1 cycle. A change on controlSingal or any entry at cycle n appears on out after the edge ending cycle n.
- Throughput: a new selection can be made every cycle.
- Reset deasserted: on the first edge with reset = 0, out loads the current sel_value.
- Reset asserted mid-operation:
  - reset has priority over selection.
  - out goes to 0 at the next edge regardless of controlSingal.
- Simultaneous change of controlSingal and the selected entry in the same cycle: out reflects the new entry under the new code after one edge.
- Changes on non-selected entries have no effect on out.
- Between edges, out is stable. It has no glitches from input activity.

## Test plan
- Reset check: reset = 1 with controlSingal = 5 and entry5 = 32'hFFFF_FFFF, then one edge -> out = 32'h0000_0000. Hold reset for 3 edges -> out stays 0.
- Full sweep with reset = 0 and controlSingal stepped 0→7, one code per cycle. Entry values:
  - entry0 = 32'h0000_FFFF, entry1 = 32'h0000_01FF, entry2 = 32'h0000_001F, entry3 = 32'h0000_0001;
  - entry4 = 32'h0000_0000, entry5 = 32'hFFFF_FFFF, entry6 = 32'hF000_FFFF, entry7 = 32'hAAAA_FFFF.
  - Required: each edge after a code is applied -> out equals that entry. Code 7 followed by code 0 -> out returns to 32'h0000_FFFF.
- Latency check: switch controlSingal 3→6 at cycle n -> out = 32'h0000_0001 through cycle n and 32'hF000_FFFF from the edge ending cycle n.
- Isolation: controlSingal = 2, toggle entry0/1/3–7 to random values each cycle -> out stays 32'h0000_001F.
- Mid-stream reset: controlSingal = 7 and running, assert reset for one cycle -> out = 0 for exactly one cycle, then 32'hAAAA_FFFF.
- Live entry tracking: controlSingal = 4, entry4 counts 0,1,2,… per cycle -> out follows the count with one-cycle delay.
